// File: rtl/acacia_arb_pkg.sv
// ------------------------------------------------------------------
// acacia_arb_pkg: shared types and constants for the hold arbiter
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package acacia_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int         NUM_REQ    = 3;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  // Client index successor, wrapping 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick3.sv
// ------------------------------------------------------------------
// rr_pick3: combinational round-robin pick among three requesters
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_pick3
  import acacia_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               valid,
  output logic [1:0]         idx
);

  logic [3:0] req_ext;
  logic [1:0] cand;

  assign req_ext = {1'b0, req};

  // Scan ptr, ptr+1, ptr+2 (mod 3); first requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = OWNER_NONE;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && req_ext[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_hold_arbiter.sv
// ------------------------------------------------------------------
// rr_hold_arbiter: 3-client round-robin arbiter, bounded hold, 1-cycle gap
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_hold_arbiter
  import acacia_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r0,
  input  logic       r1,
  input  logic       r2,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic [1:0] owner
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         owner_q, owner_d;
  logic [3:0]         hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] req;
  logic [3:0]         req_ext;
  logic               pick_valid;
  logic [1:0]         pick_idx;

  assign req     = {r2, r1, r0};
  assign req_ext = {1'b0, req};

  rr_pick3 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      GRANT: begin
        if (!req_ext[owner_q] || (hold_cnt_q == HOLD_LAST)) begin
          state_d    = GAP;
          ptr_d      = next_idx(owner_q);
          owner_d    = OWNER_NONE;
          hold_cnt_d = 4'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      IDLE, GAP: begin
        hold_cnt_d = 4'd0;
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
        end else begin
          state_d = IDLE;
          owner_d = OWNER_NONE;
        end
      end
      default: begin
        state_d    = IDLE;
        owner_d    = OWNER_NONE;
        hold_cnt_d = 4'd0;
      end
    endcase
  end

  // Grants are a registered decode of the next owner, so they track owner exactly.
  always_comb begin
    grant_d = '0;
    case (owner_d)
      2'd0:    grant_d = 3'b001;
      2'd1:    grant_d = 3'b010;
      2'd2:    grant_d = 3'b100;
      default: grant_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      owner_q    <= OWNER_NONE;
      hold_cnt_q <= 4'd0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
    end
  end

  assign a0    = grant_q[0];
  assign a1    = grant_q[1];
  assign a2    = grant_q[2];
  assign owner = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_hold_arbiter.sv
// ------------------------------------------------------------------
// tb_rr_hold_arbiter: directed self-checking bench for rr_hold_arbiter
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_rr_hold_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r0, r1, r2;
  logic       a0, a1, a2;
  logic [1:0] owner;
  logic       s0, s1, s2;
  logic       b0, b1, b2;
  logic [1:0] owner1;

  int checks = 0;
  int errors = 0;

  localparam int N = 3;
  localparam int E_HOLD[10]  = '{0, 0, 0, 0, N, 0, 0, 0, 0, N};
  localparam int E_ALL[19]   = '{0, 0, 0, 0, N, 1, 1, 1, 1, N,
                                 2, 2, 2, 2, N, 0, 0, 0, 0};
  localparam int E_DROP[5]   = '{1, 1, N, 2, N};
  localparam int E_H1[6]     = '{0, N, 2, N, 0, N};
  localparam int E_H1PTR[6]  = '{0, 1, 1, 0, 0, 1};

  always #5 clk = ~clk;

  rr_hold_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .r0(r0), .r1(r1), .r2(r2),
    .a0(a0), .a1(a1), .a2(a2), .owner(owner)
  );

  rr_hold_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .r0(s0), .r1(s1), .r2(s2),
    .a0(b0), .a1(b1), .a2(b2), .owner(owner1)
  );

  // Expected {a2,a1,a0,owner} for a given owner value.
  function automatic logic [4:0] exp_vec(input int own);
    case (own)
      0:       return 5'b001_00;
      1:       return 5'b010_01;
      2:       return 5'b100_10;
      default: return 5'b000_11;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_ptr(input string tag, input logic [1:0] obs, input int exp);
    checks++;
    assert (obs === 2'(exp)) else begin
      errors++;
      $error("FAIL %s observed_ptr=%0d expected_ptr=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {r0, r1, r2} = 3'b000;
    {s0, s1, s2} = 3'b000;
    repeat (2) @(negedge clk);
    chk("reset_out", {a2, a1, a0, owner}, exp_vec(N));
    chk("reset_out_h1", {b2, b1, b0, owner1}, exp_vec(N));
    chk_ptr("reset_ptr", dut.ptr_q, 0);
    rst_n = 1'b1;

    // Single requester held 10 cycles: 4 granted, 1 gap, 4 granted, gap.
    r0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold_r0[%0d]", i), {a2, a1, a0, owner}, exp_vec(E_HOLD[i]));
    end
    r0 = 1'b0;
    @(negedge clk);
    chk("hold_r0_idle", {a2, a1, a0, owner}, exp_vec(N));
    chk_ptr("hold_r0_ptr", dut.ptr_q, 1);

    // All three requesting: rotation 0,1,2,0 with one dead cycle between.
    pulse_reset();
    {r0, r1, r2} = 3'b111;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      chk($sformatf("all_req[%0d]", i), {a2, a1, a0, owner}, exp_vec(E_ALL[i]));
    end
    {r0, r1, r2} = 3'b000;

    // r1 drops after two grant cycles; r2 takes over after the gap.
    pulse_reset();
    {r1, r2} = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("drop_r1[%0d]", i), {a2, a1, a0, owner}, exp_vec(E_DROP[i]));
      if (i == 1) r1 = 1'b0;
      if (i == 3) r2 = 1'b0;
    end
    chk_ptr("drop_r1_ptr", dut.ptr_q, 0);
    @(negedge clk);

    // Move ptr off zero, then reset asynchronously mid-grant.
    r0 = 1'b1;
    @(negedge clk);
    chk("pre_rst_g0", {a2, a1, a0, owner}, exp_vec(0));
    r0 = 1'b0;
    @(negedge clk);
    chk("pre_rst_gap", {a2, a1, a0, owner}, exp_vec(N));
    chk_ptr("pre_rst_ptr", dut.ptr_q, 1);
    r2 = 1'b1;
    @(negedge clk);
    chk("pre_rst_g2", {a2, a1, a0, owner}, exp_vec(2));
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop", {a2, a1, a0, owner}, exp_vec(N));
    chk_ptr("async_ptr", dut.ptr_q, 0);
    @(negedge clk);
    chk("held_in_reset", {a2, a1, a0, owner}, exp_vec(N));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_g2", {a2, a1, a0, owner}, exp_vec(2));
    chk_ptr("post_rst_ptr", dut.ptr_q, 0);
    r2 = 1'b0;
    repeat (2) @(negedge clk);

    // MAX_HOLD=1 instance: alternate single-cycle grants to 0 and 2.
    {s0, s2} = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("h1[%0d]", i), {b2, b1, b0, owner1}, exp_vec(E_H1[i]));
      chk_ptr($sformatf("h1_ptr[%0d]", i), dut1.ptr_q, E_H1PTR[i]);
    end
    {s0, s2} = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/rr_hold_arbiter.md
RR_HOLD_ARBITER -- requirements
Module: rr_hold_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles per ownership; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 r0, r1, r2  input  1 each  requests from clients 0..2; level-sensitive, sampled on clk rising edge.
REQ-005 a0, a1, a2  output  1 each  grants to clients 0..2; registered; at most one high in any cycle.
REQ-006 owner  output  2  index of granted client (0..2); 3 when no grant; registered, consistent with a0..a2 every cycle.

Function
REQ-007 The block SHALL implement FSM states IDLE, GRANT, GAP.
REQ-008 IDLE: no grant; if any request sampled high, SHALL pick a winner and enter GRANT; else stay IDLE.
REQ-009 Winner selection SHALL be round-robin: first requester found scanning ptr, ptr+1, ptr+2 (mod 3), where ptr is a 2-bit pointer.
REQ-010 Grant to the winner SHALL appear in the cycle after the request is sampled (1-cycle latency, IDLE to GRANT).
REQ-011 On GRANT entry, hold_cnt SHALL be 0; it SHALL increment by 1 each GRANT cycle.
REQ-012 GRANT exit SHALL occur at the edge where the owner's request is sampled low OR hold_cnt == MAX_HOLD-1, whichever comes first.
REQ-013 A grant SHALL therefore last min(request-high cycles, MAX_HOLD) cycles; with MAX_HOLD=1, exactly one cycle.
REQ-014 On GRANT exit: next state GAP; ptr <= (owner+1) mod 3; all grants low and owner=3 in GAP.
REQ-015 GAP SHALL last exactly one cycle and SHALL arbitrate exactly as IDLE (with the updated ptr); no requests sends it to IDLE.
REQ-016 Back-to-back ownership SHALL therefore have exactly one dead cycle between grants; a forcibly revoked client still requesting SHALL be re-granted only after all other requesters are served in rotation.
REQ-017 Requests from non-owners during GRANT SHALL be ignored until GAP; no pre-emption.
REQ-018 ptr SHALL change only on GRANT exit, never in IDLE or GAP.
REQ-019 Simultaneous requests in IDLE/GAP SHALL resolve solely by REQ-009; no fixed-priority fallback.

Reset
REQ-020 While rst_n low: state=IDLE, ptr=0, hold_cnt=0, a0=a1=a2=0, owner=3, asynchronously.
REQ-021 Reset asserted mid-GRANT SHALL drop the grant immediately, without waiting for a clock edge.
REQ-022 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge with rst_n high.

Structure
REQ-023 Shared package acacia_arb_pkg SHALL hold the FSM state enum (IDLE, GRANT, GAP), NUM_REQ=3 and OWNER_NONE=2'd3.
REQ-024 Round-robin selection SHALL be a combinational sub-module rr_pick3 (inputs req[2:0], ptr; outputs valid, idx).
REQ-025 Grant outputs SHALL be registered decodes of owner; no combinational path from r* to a*.

Verification (MAX_HOLD=4 unless noted)
REQ-026 After reset, r0=1 held 10 cycles -> a0 high 4 cycles, 1 low cycle, then 4 high again; owner 0/3 in step.
REQ-027 After reset, r0=r1=r2=1 continuously -> grant order 0,1,2,0 with 4-cycle grants and 1-cycle gaps; never two grants high.
REQ-028 r1 granted, r1 dropped after 2 cycles with r2=1 -> a1 high 2 cycles, GAP, a2 high next cycle.
REQ-029 MAX_HOLD=1, r0=r2=1 -> a0,gap,a2,gap,a0 pattern; ptr sequence 0,1,0 after exits.
REQ-030 rst_n pulsed low mid-grant (between edges) -> a* drop and owner=3 same cycle; after release, r2=1 alone -> a2 one cycle later, ptr restarts at 0.
